// File: rtl/cycle_timer.sv
// Phase timer for the traffic-light enable decoder: prescaled 6-bit cycle counter,
// pedestrian push-button synchroniser/edge detector and per-cycle PED flag.
module cycle_timer #(
  parameter int unsigned TICK_DIV       = 1,
  parameter int unsigned CYCLE_LEN_NORM = 32,
  parameter int unsigned CYCLE_LEN_PED  = 42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       ped_btn,
  output logic [5:0] counter,
  output logic       ped_active,
  output logic       ped_pending,
  output logic       cycle_start
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
  localparam logic [5:0]  LAST_NORM  = 6'(CYCLE_LEN_NORM - 1);
  localparam logic [5:0]  LAST_PED   = 6'(CYCLE_LEN_PED - 1);

  logic [15:0] prescaler;
  logic        btn_sync1;
  logic        btn_sync2;
  logic        btn_prev;
  logic        tick;
  logic        btn_edge;
  logic        wrap;
  logic [5:0]  last;

  always_comb begin
    tick     = run && (prescaler == PRESC_LAST);
    last     = ped_active ? LAST_PED : LAST_NORM;
    wrap     = tick && (counter == last);
    btn_edge = btn_sync2 && !btn_prev;
  end

  // Prescaler only moves while running, so a paused timer resumes mid-tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else if (run) begin
      prescaler <= prescaler + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter     <= '0;
      cycle_start <= 1'b0;
    end else begin
      cycle_start <= wrap;
      if (wrap) begin
        counter <= '0;
      end else if (tick) begin
        counter <= counter + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      btn_prev  <= 1'b0;
    end else begin
      btn_sync1 <= ped_btn;
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
    end
  end

  // An edge seen in the wrap clk is served by that same wrap instead of waiting a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_active  <= 1'b0;
      ped_pending <= 1'b0;
    end else if (wrap) begin
      ped_active  <= ped_pending || btn_edge;
      ped_pending <= 1'b0;
    end else begin
      ped_pending <= ped_pending || btn_edge;
    end
  end

endmodule
